// File: rtl/ckrs_pkg.sv
// CKRSPkg: clock/reset bundle shared by all blocks in the recovered clock domain.
package CKRSPkg;
    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;
endpackage

// File: rtl/gbt_pattern_checker_pkg.sv
// MCPkg: checker state encoding, default thresholds and word-validity helper.
package MCPkg;
    typedef enum logic [1:0] {IDLE, SEEK, LOCKED} state_t;
    localparam int LOCK_THRESHOLD_DEF   = 4;
    localparam int UNLOCK_THRESHOLD_DEF = 8;
    localparam int RUN_W                = 16;
    function automatic logic is_valid(input logic [63:0] word);
        return word[63:32] == word[31:0];
    endfunction
endpackage

// File: rtl/gbt_pattern_checker_sat_counter.sv
// sat_counter: counter with synchronous clear and selectable saturate or wrap.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic         sat,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !(sat && &count))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/gbt_pattern_checker.sv
// gbt_pattern_checker: locks onto the duplicated 32-bit counting pattern and counts errors.
module gbt_pattern_checker
    import MCPkg::*;
    import CKRSPkg::*;
#(
    parameter int LOCK_THRESHOLD   = LOCK_THRESHOLD_DEF,
    parameter int UNLOCK_THRESHOLD = UNLOCK_THRESHOLD_DEF
) (
    input  ckrs_t        ClkRs_ix,
    input  logic         RxReady_i,
    input  logic         RxClken_i,
    input  logic         Enable_i,
    input  logic         ClearCounters_i,
    input  logic [63:0]  MotorData_ib64,
    output logic         Locked_o,
    output logic         Error_o,
    output logic [31:0]  ErrorCount_ob32,
    output logic [31:0]  WordCount_ob32,
    output logic         LockLost_o,
    output logic [31:0]  Expected_ob32
);
    logic             clk, rst, active, sample, valid, match;
    logic [31:0]      low, expected, expected_n;
    logic [RUN_W-1:0] good_run, good_n, bad_run, bad_n, good_seek;
    logic             err_n, inc_err, inc_word, lost_set, error_q, lock_lost;
    state_t           state, state_n;

    assign clk    = ClkRs_ix.clk;
    assign rst    = ClkRs_ix.reset;
    assign active = RxReady_i & Enable_i;
    assign sample = RxClken_i & active;
    assign low    = MotorData_ib64[31:0];
    assign valid  = is_valid(MotorData_ib64);
    assign match  = valid && low == expected;
    // A match only extends a run already in progress; any other valid word restarts it at 1.
    assign good_seek = (match && good_run != '0) ? good_run + 1'b1 : (valid ? RUN_W'(1) : '0);

    always_comb begin
        state_n    = state;
        expected_n = expected;
        good_n     = good_run;
        bad_n      = bad_run;
        err_n      = 1'b0;
        inc_err    = 1'b0;
        inc_word   = 1'b0;
        lost_set   = 1'b0;
        if (!active) begin
            state_n    = IDLE;
            expected_n = '0;
            good_n     = '0;
            bad_n      = '0;
        end else if (state == IDLE) begin
            state_n = SEEK;
            good_n  = '0;
        end else if (sample && state == SEEK) begin
            expected_n = valid ? low + 1'b1 : expected;
            good_n     = good_seek;
            if (good_seek == RUN_W'(LOCK_THRESHOLD)) begin
                state_n = LOCKED;
                bad_n   = '0;
            end
        end else if (sample && state == LOCKED) begin
            expected_n = expected + 1'b1;
            inc_word   = 1'b1;
            err_n      = !match;
            inc_err    = !match;
            bad_n      = match ? '0 : bad_run + 1'b1;
            if (!match && bad_run + 1'b1 == RUN_W'(UNLOCK_THRESHOLD)) begin
                state_n  = SEEK;
                good_n   = '0;
                lost_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            expected  <= '0;
            good_run  <= '0;
            bad_run   <= '0;
            error_q   <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_n;
            expected  <= expected_n;
            good_run  <= good_n;
            bad_run   <= bad_n;
            error_q   <= err_n;
            lock_lost <= ClearCounters_i ? 1'b0 : (lock_lost | lost_set);
        end
    end

    sat_counter #(.W(32)) u_err_cnt (
        .clk(clk), .rst(rst), .inc(inc_err), .clr(ClearCounters_i), .sat(1'b1), .count(ErrorCount_ob32)
    );

    sat_counter #(.W(32)) u_word_cnt (
        .clk(clk), .rst(rst), .inc(inc_word), .clr(ClearCounters_i), .sat(1'b0), .count(WordCount_ob32)
    );

    assign Locked_o      = state == LOCKED;
    assign Error_o       = error_q;
    assign LockLost_o    = lock_lost;
    assign Expected_ob32 = expected;
endmodule

// File: tb/tb_gbt_pattern_checker.sv
// tb_gbt_pattern_checker: directed vectors with hand-computed expectations.
module tb_gbt_pattern_checker;
    import CKRSPkg::*;

    ckrs_t        ck;
    logic         ready, clken, enable, clr;
    logic [63:0]  data;
    logic         locked, error, lock_lost;
    logic [31:0]  err_cnt, word_cnt, expected;
    int           n_vec, n_err, pulses;

    gbt_pattern_checker dut (
        .ClkRs_ix(ck), .RxReady_i(ready), .RxClken_i(clken), .Enable_i(enable),
        .ClearCounters_i(clr), .MotorData_ib64(data), .Locked_o(locked), .Error_o(error),
        .ErrorCount_ob32(err_cnt), .WordCount_ob32(word_cnt), .LockLost_o(lock_lost),
        .Expected_ob32(expected)
    );

    initial ck.clk = 1'b0;
    always #5 ck.clk = ~ck.clk;

    always @(negedge ck.clk) pulses += int'(error);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One sampled word followed by two idle cycles (clken every 3rd cycle).
    task automatic send(input logic [63:0] w, input logic c = 1'b0);
        @(negedge ck.clk);
        data  = w;
        clken = 1'b1;
        clr   = c;
        @(negedge ck.clk);
        clken = 1'b0;
        clr   = 1'b0;
        @(negedge ck.clk);
    endtask

    task automatic send_cnt(input logic [31:0] c);
        send({c, c});
    endtask

    task automatic send_bad(input logic [31:0] c);
        send({32'hDEAD0000 ^ c, c});
    endtask

    initial begin
        int p0;
        n_vec = 0; n_err = 0; pulses = 0;
        ck.reset = 1'b1; ready = 0; enable = 0; clken = 0; clr = 0; data = '0;
        repeat (2) @(negedge ck.clk);
        check("rst_locked", 32'(locked), 0);
        check("rst_error", 32'(error), 0);
        check("rst_errcnt", err_cnt, 0);
        check("rst_wordcnt", word_cnt, 0);
        check("rst_locklost", 32'(lock_lost), 0);
        check("rst_expected", expected, 0);
        ck.reset = 1'b0; ready = 1; enable = 1;
        repeat (2) @(negedge ck.clk);
        for (int i = 0; i < 3; i++) send_cnt(i);
        check("seek_not_locked", 32'(locked), 0);
        send_cnt(3);
        check("lock_after_4", 32'(locked), 1);
        check("lock_expected", expected, 4);
        for (int i = 4; i < 8; i++) send_cnt(i);
        check("wordcnt_4", word_cnt, 4);
        check("errcnt_0", err_cnt, 0);
        for (int i = 8; i < 'h100; i++) send_cnt(i);
        p0 = pulses;
        send(64'h12345678_12345678);
        check("single_err_pulse", 32'(pulses - p0), 1);
        check("single_errcnt", err_cnt, 1);
        check("single_locked", 32'(locked), 1);
        check("single_wordcnt", word_cnt, 253);
        for (int i = 'h101; i < 'h104; i++) send_cnt(i);
        check("no_resync_errcnt", err_cnt, 1);
        check("no_resync_expected", expected, 32'h104);
        @(negedge ck.clk); clr = 1; @(negedge ck.clk); clr = 0;
        check("clr_errcnt", err_cnt, 0);
        check("clr_wordcnt", word_cnt, 0);
        for (int i = 0; i < 7; i++) send_bad(i);
        check("bad7_locked", 32'(locked), 1);
        send_bad(7);
        check("bad8_unlocked", 32'(locked), 0);
        check("bad8_locklost", 32'(lock_lost), 1);
        check("bad8_errcnt", err_cnt, 8);
        for (int i = 'h200; i < 'h203; i++) send_cnt(i);
        check("relock_3_not_yet", 32'(locked), 0);
        send_cnt('h203);
        check("relock_4", 32'(locked), 1);
        @(negedge ck.clk); force dut.u_err_cnt.count = 32'hFFFFFFFE;
        @(negedge ck.clk); release dut.u_err_cnt.count;
        send_bad(0);
        check("sat_first", err_cnt, 32'hFFFFFFFF);
        send_bad(1);
        send_bad(2);
        check("sat_hold", err_cnt, 32'hFFFFFFFF);
        check("sat_locked", 32'(locked), 1);
        send_cnt('h207);
        check("sat_locklost_before_clr", 32'(lock_lost), 1);
        p0 = pulses;
        send({32'hBADBAD00, 32'h208}, 1'b1);
        check("clr_err_errcnt", err_cnt, 0);
        check("clr_err_pulse", 32'(pulses - p0), 1);
        check("clr_err_locklost", 32'(lock_lost), 0);
        check("clr_err_wordcnt", word_cnt, 0);
        send_cnt('h209);
        send_bad('h20A);
        @(negedge ck.clk); ready = 0; @(negedge ck.clk);
        check("drop_locked", 32'(locked), 0);
        check("drop_expected", expected, 0);
        check("drop_errcnt_kept", err_cnt, 1);
        check("drop_wordcnt_kept", word_cnt, 2);
        ready = 1;
        repeat (2) @(negedge ck.clk);
        send_cnt('h500);
        check("seek_expected", expected, 32'h501);
        #2 ck.reset = 1'b1;
        #1;
        check("async_expected", expected, 0);
        check("async_errcnt", err_cnt, 0);
        check("async_wordcnt", word_cnt, 0);
        check("async_locked", 32'(locked), 0);
        @(negedge ck.clk); ck.reset = 1'b0;
        repeat (2) @(negedge ck.clk);
        for (int i = 'h600; i < 'h604; i++) send_cnt(i);
        check("post_rst_relock", 32'(locked), 1);
        check("post_rst_locklost", 32'(lock_lost), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
